// File: rtl/ifm_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifm_load_ctrl_if
// Beat stream from the DMA/bus side into the IFM load controller.
//   in_valid_i        : beat valid (master -> slave)
//   in_ready_o        : beat accepted when valid & ready (slave -> master)
//   in_sparsemap_i    : BUS_SIZE-bit sparsemap of the beat
//   in_nonzero_data_i : BUS_SIZE nonzero bytes of the beat
// master = DMA/bus producer, slave = ifm_load_ctrl.
// ---------------------------------------------------------------------------
interface ifm_load_ctrl_if #(
  parameter int BUS_SIZE = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [BUS_SIZE-1:0]   in_sparsemap_i;
  logic [BUS_SIZE*8-1:0] in_nonzero_data_i;

  modport master (
    output in_valid_i,
    output in_sparsemap_i,
    output in_nonzero_data_i,
    input  in_ready_o
  );

  modport slave (
    input  in_valid_i,
    input  in_sparsemap_i,
    input  in_nonzero_data_i,
    output in_ready_o
  );
endinterface

// File: rtl/ifm_load_ctrl.sv
// ---------------------------------------------------------------------------
// ifm_load_ctrl
// Chunk-level ring-buffer controller for the IFM SRAM bank array.
// SRAM_IFM_NUM slots of WR_DAT_CYC_NUM beats each. Incoming beats are
// written straight through to memory at the tail (wr_chunk/wr_dat); the
// compute side walks the head (rd_chunk/rd_dat) and may keep a chunk for
// reuse instead of releasing it. chunk_cnt counts complete, unreleased
// chunks and is the only thing that gates writes and reads.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   in_if (slave)       : beat stream (valid/ready, sparsemap, nonzero data)
//   wr_*_o              : memory write strobe, data and beat/slot indices
//   rd_en_i, rd_keep_i  : consumer takes a beat / keeps chunk on last beat
//   chunk_valid_o       : head chunk complete and readable
//   rd_dat_count_o, rd_chunk_count_o : read beat/slot indices
//   chunk_cnt_o, full_o, empty_o     : occupancy
// ---------------------------------------------------------------------------
module ifm_load_ctrl #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int SRAM_IFM_NUM   = 4,
  localparam int DAT_W         = $clog2(WR_DAT_CYC_NUM),
  localparam int CHK_W         = $clog2(SRAM_IFM_NUM),
  localparam int CNT_W         = CHK_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ifm_load_ctrl_if.slave        in_if,
  output logic                  wr_valid_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic [DAT_W-1:0]      wr_dat_count_o,
  output logic [CHK_W-1:0]      wr_chunk_count_o,
  input  logic                  rd_en_i,
  input  logic                  rd_keep_i,
  output logic                  chunk_valid_o,
  output logic [DAT_W-1:0]      rd_dat_count_o,
  output logic [CHK_W-1:0]      rd_chunk_count_o,
  output logic [CNT_W-1:0]      chunk_cnt_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DAT_W-1:0] wr_dat_q, wr_dat_d;
  logic [CHK_W-1:0] wr_chunk_q, wr_chunk_d;
  logic [DAT_W-1:0] rd_dat_q, rd_dat_d;
  logic [CHK_W-1:0] rd_chunk_q, rd_chunk_d;
  logic [CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;

  logic full_s, empty_s, wr_accept_s, wr_done_s, rd_fire_s, rd_last_s, rel_s;

  // Occupancy flags, handshake and event decode
  always_comb begin
    full_s      = (chunk_cnt_q == CNT_W'(SRAM_IFM_NUM));
    empty_s     = (chunk_cnt_q == CNT_W'(0));
    // Reset gates the strobe so a beat presented during reset is never written.
    wr_accept_s = in_if.in_valid_i & ~full_s & ~rst_i;
    wr_done_s   = wr_accept_s & (wr_dat_q == DAT_W'(WR_DAT_CYC_NUM - 1));
    // Reads only count against complete chunks; a partial tail is invisible.
    rd_fire_s   = rd_en_i & ~empty_s;
    rd_last_s   = (rd_dat_q == DAT_W'(WR_DAT_CYC_NUM - 1));
    rel_s       = rd_fire_s & rd_last_s & ~rd_keep_i;
  end

  // Output drive: write path is a zero-latency pass-through
  always_comb begin
    in_if.in_ready_o  = ~full_s;
    wr_valid_o        = wr_accept_s;
    wr_sparsemap_o    = in_if.in_sparsemap_i;
    wr_nonzero_data_o = in_if.in_nonzero_data_i;
    wr_dat_count_o    = wr_dat_q;
    wr_chunk_count_o  = wr_chunk_q;
    chunk_valid_o     = ~empty_s;
    rd_dat_count_o    = rd_dat_q;
    rd_chunk_count_o  = rd_chunk_q;
    chunk_cnt_o       = chunk_cnt_q;
    full_o            = full_s;
    empty_o           = empty_s;
  end

  // Next-state for write pointer, read pointer and chunk count
  always_comb begin
    wr_dat_d    = wr_dat_q;
    wr_chunk_d  = wr_chunk_q;
    rd_dat_d    = rd_dat_q;
    rd_chunk_d  = rd_chunk_q;
    chunk_cnt_d = chunk_cnt_q;

    if (wr_done_s) begin
      wr_dat_d   = DAT_W'(0);
      wr_chunk_d = wr_chunk_q + CHK_W'(1);  // power-of-2 slot count wraps naturally
    end else if (wr_accept_s) begin
      wr_dat_d   = wr_dat_q + DAT_W'(1);
    end else begin
      wr_dat_d   = wr_dat_q;
    end

    if (rd_fire_s && rd_last_s) begin
      rd_dat_d = DAT_W'(0);
      // Keeping the chunk replays the same slot from beat 0.
      if (rel_s) begin
        rd_chunk_d = rd_chunk_q + CHK_W'(1);
      end else begin
        rd_chunk_d = rd_chunk_q;
      end
    end else if (rd_fire_s) begin
      rd_dat_d = rd_dat_q + DAT_W'(1);
    end else begin
      rd_dat_d = rd_dat_q;
    end

    case ({wr_done_s, rel_s})
      2'b10:   chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
      2'b01:   chunk_cnt_d = chunk_cnt_q - CNT_W'(1);
      default: chunk_cnt_d = chunk_cnt_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_dat_q    <= '0;
      wr_chunk_q  <= '0;
      rd_dat_q    <= '0;
      rd_chunk_q  <= '0;
      chunk_cnt_q <= '0;
    end else begin
      wr_dat_q    <= wr_dat_d;
      wr_chunk_q  <= wr_chunk_d;
      rd_dat_q    <= rd_dat_d;
      rd_chunk_q  <= rd_chunk_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifm_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifm_load_ctrl
// Directed table of per-cycle vectors for the ring-buffer corner cases,
// followed by randomized traffic checked against a counting model of the
// buffer (total beats written, beats read in current chunk, chunks released).
// ---------------------------------------------------------------------------
module tb_ifm_load_ctrl;
  localparam int BUS  = 32;
  localparam int W    = 4;
  localparam int N    = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic rd_en_i, rd_keep_i;
  logic wr_valid_o, chunk_valid_o, full_o, empty_o;
  logic [BUS-1:0]   wr_sparsemap_o;
  logic [BUS*8-1:0] wr_nonzero_data_o;
  logic [1:0] wr_dat_count_o, wr_chunk_count_o, rd_dat_count_o, rd_chunk_count_o;
  logic [2:0] chunk_cnt_o;

  int checks = 0;
  int errors = 0;

  ifm_load_ctrl_if #(.BUS_SIZE(BUS)) in_if ();

  ifm_load_ctrl #(.BUS_SIZE(BUS), .WR_DAT_CYC_NUM(W), .SRAM_IFM_NUM(N)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .in_if             (in_if),
    .wr_valid_o        (wr_valid_o),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .wr_dat_count_o    (wr_dat_count_o),
    .wr_chunk_count_o  (wr_chunk_count_o),
    .rd_en_i           (rd_en_i),
    .rd_keep_i         (rd_keep_i),
    .chunk_valid_o     (chunk_valid_o),
    .rd_dat_count_o    (rd_dat_count_o),
    .rd_chunk_count_o  (rd_chunk_count_o),
    .chunk_cnt_o       (chunk_cnt_o),
    .full_o            (full_o),
    .empty_o           (empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Watchdog: the run is bounded by construction, this only guards a stuck sim.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit rst, vld, rd, keep;
    bit rdy, wv;
    int wdat, wchk, rdat, rchk, cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit vld, bit rd, bit keep, bit rdy, bit wv,
                              int wdat, int wchk, int rdat, int rchk, int cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rd = rd; v.keep = keep;
    v.rdy = rdy; v.wv = wv;
    v.wdat = wdat; v.wchk = wchk; v.rdat = rdat; v.rchk = rchk; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable counter/flag against one expected state
  task automatic chk_state(string tag, bit rdy, bit wv, int wdat, int wchk,
                           int rdat, int rchk, int cnt);
    chk({tag, ".in_ready"},    256'(in_if.in_ready_o), 256'(rdy));
    chk({tag, ".wr_valid"},    256'(wr_valid_o),       256'(wv));
    chk({tag, ".wr_dat"},      256'(wr_dat_count_o),   256'(wdat));
    chk({tag, ".wr_chunk"},    256'(wr_chunk_count_o), 256'(wchk));
    chk({tag, ".rd_dat"},      256'(rd_dat_count_o),   256'(rdat));
    chk({tag, ".rd_chunk"},    256'(rd_chunk_count_o), 256'(rchk));
    chk({tag, ".chunk_cnt"},   256'(chunk_cnt_o),      256'(cnt));
    chk({tag, ".full"},        256'(full_o),           256'(cnt == N));
    chk({tag, ".empty"},       256'(empty_o),          256'(cnt == 0));
    chk({tag, ".chunk_valid"}, 256'(chunk_valid_o),    256'(cnt != 0));
  endtask

  task automatic drive(bit rst, bit vld, bit rd, bit keep);
    rst_i = rst;
    in_if.in_valid_i = vld;
    rd_en_i = rd;
    rd_keep_i = keep;
    in_if.in_sparsemap_i = $urandom;
    for (int b = 0; b < 8; b++) in_if.in_nonzero_data_i[b*32 +: 32] = $urandom;
  endtask

  // Model of the buffer in terms of totals rather than pointers
  int m_wr_total, m_rd_pos, m_released;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // ---------------- directed table ----------------
    add(1,1,0,0, 1,0, 0,0, 0,0, 0);                          // reset gates wr_valid
    for (int k = 0; k < 16; k++)                             // fill all 4 slots
      add(0,1,0,0, 1,1, k%4, k/4, 0,0, k/4);
    add(0,1,0,0, 0,0, 0,0, 0,0, 4);                          // 17th beat held, tail wrapped 3->0
    for (int j = 0; j < 4; j++)                              // release chunk 0 while full
      add(0,1,1,0, 0,0, 0,0, j,0, 4);
    for (int j = 0; j < 4; j++)                              // held beat lands in slot 0 next cycle
      add(0,1,0,0, 1,1, j,0, 0,1, 3);
    for (int i = 0; i < 16; i++)                             // 3x reuse then release
      add(0,0,1,(i < 12), 0,0, 0,1, i%4,1, 4);
    add(0,0,0,0, 1,0, 0,1, 0,2, 3);
    for (int j = 0; j < 4; j++)                              // drop to 2 chunks
      add(0,0,1,0, 1,0, 0,1, j,2, 3);
    for (int j = 0; j < 4; j++)                              // write-complete + release same cycle
      add(0,1,1,0, 1,1, j,1, j,3, 2);
    add(0,0,0,0, 1,0, 0,2, 0,0, 2);                          // count held at 2, read head wrapped 3->0
    for (int i = 0; i < 8; i++)                              // drain
      add(0,0,1,0, 1,0, 0,2, i%4, i/4, 2 - i/4);
    add(0,0,1,1, 1,0, 0,2, 0,2, 0);                          // rd_en while empty ignored
    add(0,0,1,0, 1,0, 0,2, 0,2, 0);
    add(0,1,0,0, 1,1, 0,2, 0,2, 0);                          // two beats of a chunk
    add(0,1,0,0, 1,1, 1,2, 0,2, 0);
    add(1,1,0,0, 1,0, 2,2, 0,2, 0);                          // reset mid-chunk
    add(0,0,0,0, 1,0, 0,0, 0,0, 0);                          // everything cleared

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].rd, vecs[i].keep);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].wv, vecs[i].wdat,
                vecs[i].wchk, vecs[i].rdat, vecs[i].rchk, vecs[i].cnt);
    end

    // ---------------- randomized traffic vs model ----------------
    m_wr_total = 0; m_rd_pos = 0; m_released = 0;
    @(negedge clk_i);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      int  cnt;
      bit  rst, vld, rd, keep, acc;
      @(negedge clk_i);
      rst  = (c == 0) || ($urandom_range(0, 199) == 0);
      vld  = ($urandom_range(0, 9) < 7);
      rd   = ($urandom_range(0, 9) < 6);
      keep = ($urandom_range(0, 9) < 3);
      drive(rst, vld, rd, keep);
      #1;
      cnt = m_wr_total / W - m_released;
      acc = vld && (cnt < N) && !rst;
      chk_state("rnd", cnt < N, acc, m_wr_total % W, (m_wr_total / W) % N,
                m_rd_pos, m_released % N, cnt);
      chk("rnd.wr_sparsemap", 256'(wr_sparsemap_o), 256'(in_if.in_sparsemap_i));
      chk("rnd.wr_nonzero",   wr_nonzero_data_o,     in_if.in_nonzero_data_i);
      // Advance the model to what the clock edge will produce
      if (rst) begin
        m_wr_total = 0; m_rd_pos = 0; m_released = 0;
      end else begin
        if (rd && cnt > 0) begin
          if (m_rd_pos == W - 1) begin
            m_rd_pos = 0;
            if (!keep) m_released++;
          end else begin
            m_rd_pos++;
          end
        end
        if (acc) m_wr_total++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
